// File: rtl/regfile_fwd_sb.sv
// rtl/regfile_fwd_sb.sv - register file with prioritised forwarding and busy scoreboard
module regfile_fwd_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NFWD   = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NREAD*ADDR_W-1:0]             raddr,
  output logic [NREAD*DATA_W-1:0]             rdata,
  output logic [NREAD-1:0]                    rstall,
  output logic                                stall,
  input  logic                                we,
  input  logic [ADDR_W-1:0]                   waddr,
  input  logic [DATA_W-1:0]                   wdata,
  input  logic                                wclr,
  input  logic [NFWD*(DATA_W+ADDR_W+2)-1:0]   fwd_bus,
  input  logic                                busy_set,
  input  logic [ADDR_W-1:0]                   busy_addr,
  output logic [(1<<ADDR_W)-1:0]              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int FW    = DATA_W + ADDR_W + 2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_next;

  // Set is applied after clear so a newly issued long op wins a collision.
  always_comb begin
    busy_next = busy_q;
    if (we && wclr && (waddr != '0))
      busy_next[waddr] = 1'b0;
    if (busy_set && (busy_addr != '0))
      busy_next[busy_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy_q <= '0;
    end else begin
      if (we && (waddr != '0))
        mem[waddr] <= wdata;
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;

  logic [ADDR_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_d;
  logic              rd_s;
  logic              rd_hit;
  logic [FW-1:0]     f_ent;

  always_comb begin
    rdata  = '0;
    rstall = '0;
    rd_a   = '0;
    rd_d   = '0;
    rd_s   = 1'b0;
    rd_hit = 1'b0;
    f_ent  = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_a   = raddr[i*ADDR_W +: ADDR_W];
      rd_d   = mem[rd_a];
      rd_s   = 1'b0;
      rd_hit = 1'b0;
      // Walk oldest to youngest so the youngest matching source overrides.
      for (int k = NFWD - 1; k >= 0; k--) begin
        f_ent = fwd_bus[k*FW +: FW];
        if (f_ent[FW-2] && (f_ent[DATA_W +: ADDR_W] == rd_a) &&
            (f_ent[DATA_W +: ADDR_W] != '0)) begin
          rd_hit = 1'b1;
          if (f_ent[FW-1]) begin
            rd_d = f_ent[DATA_W-1:0];
            rd_s = 1'b0;
          end else begin
            rd_d = mem[rd_a];
            rd_s = 1'b1;
          end
        end
      end
      if (!rd_hit) begin
        if (we && (waddr == rd_a))
          rd_d = wdata;
        else if (busy_q[rd_a])
          rd_s = 1'b1;
      end
      if ((rd_a == '0) || rst) begin
        rd_d = '0;
        rd_s = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = rd_d;
      rstall[i]                 = rd_s;
    end
  end

  assign stall = |rstall;

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// tb/tb_regfile_fwd_sb.sv - directed self-checking bench for regfile_fwd_sb
module tb_regfile_fwd_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;
  localparam int NFWD   = 3;
  localparam int FW     = DATA_W + ADDR_W + 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NREAD*ADDR_W-1:0]   raddr;
  logic [NREAD*DATA_W-1:0]   rdata;
  logic [NREAD-1:0]          rstall;
  logic                      stall;
  logic                      we;
  logic [ADDR_W-1:0]         waddr;
  logic [DATA_W-1:0]         wdata;
  logic                      wclr;
  logic [NFWD*FW-1:0]        fwd_bus;
  logic                      busy_set;
  logic [ADDR_W-1:0]         busy_addr;
  logic [(1<<ADDR_W)-1:0]    busy;

  int vecs = 0;
  int errs = 0;

  regfile_fwd_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .NFWD(NFWD)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rstall(rstall), .stall(stall),
    .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr), .fwd_bus(fwd_bus),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] fe(input logic r, input logic w,
                                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {r, w, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; wclr = 0; waddr = 0; wdata = 0;
    busy_set = 0; busy_addr = 0; fwd_bus = '0;
  endtask

  task automatic test_reset();
    idle();
    we = 1; waddr = 5; wdata = 32'h1234;
    tick();
    idle();
    raddr = {5'd5, 5'd5};
    #1;
    vecs++; if (rdata[31:0] !== 32'h1234) begin errs++; $display("FAIL preload r5: got %h want %h", rdata[31:0], 32'h1234); end
    busy_set = 1; busy_addr = 8;
    tick();
    busy_set = 0;
    fwd_bus[0*FW +: FW] = fe(0, 1, 5, 32'h0);
    rst = 1;
    #1;
    vecs++; if (rdata !== '0) begin errs++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    vecs++; if (stall !== 1'b0 || rstall !== 2'b00) begin errs++; $display("FAIL rst_stall: got %b/%b want 0/00", stall, rstall); end
    tick();
    rst = 0;
    idle();
    #1;
    vecs++; if (rdata[31:0] !== 32'h0) begin errs++; $display("FAIL post_rst r5: got %h want 0", rdata[31:0]); end
    vecs++; if (busy !== '0) begin errs++; $display("FAIL post_rst busy: got %h want 0", busy); end
  endtask

  task automatic test_fwd_priority();
    idle();
    we = 1; waddr = 7; wdata = 32'h1111;
    tick();
    idle();
    raddr = {5'd7, 5'd7};
    fwd_bus[0*FW +: FW] = fe(1, 1, 7, 32'hAAAA);
    fwd_bus[2*FW +: FW] = fe(1, 1, 7, 32'hCCCC);
    #1;
    vecs++; if (rdata[31:0] !== 32'hAAAA) begin errs++; $display("FAIL fwd0_wins: got %h want %h", rdata[31:0], 32'hAAAA); end
    vecs++; if (rdata[63:32] !== 32'hAAAA) begin errs++; $display("FAIL fwd0_port1: got %h want %h", rdata[63:32], 32'hAAAA); end
    fwd_bus[0*FW +: FW] = fe(1, 0, 7, 32'hAAAA);
    #1;
    vecs++; if (rdata[31:0] !== 32'hCCCC) begin errs++; $display("FAIL fwd2_fallback: got %h want %h", rdata[31:0], 32'hCCCC); end
    fwd_bus = '0;
    #1;
    vecs++; if (rdata[31:0] !== 32'h1111) begin errs++; $display("FAIL array_r7: got %h want %h", rdata[31:0], 32'h1111); end
  endtask

  task automatic test_load_use();
    idle();
    raddr = {5'd0, 5'd3};
    fwd_bus[0*FW +: FW] = fe(0, 1, 3, 32'h0);
    fwd_bus[1*FW +: FW] = fe(1, 1, 3, 32'h55);
    #1;
    vecs++; if (rstall !== 2'b01 || stall !== 1'b1) begin errs++; $display("FAIL load_use_stall: got %b/%b want 01/1", rstall, stall); end
    tick();
    fwd_bus[0*FW +: FW] = fe(1, 1, 3, 32'h66);
    #1;
    vecs++; if (rdata[31:0] !== 32'h66) begin errs++; $display("FAIL load_use_data: got %h want %h", rdata[31:0], 32'h66); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL load_use_release: got %b want 0", stall); end
  endtask

  task automatic test_scoreboard();
    idle();
    raddr = {5'd0, 5'd9};
    busy_set = 1; busy_addr = 9;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL busy_set_latency: got %b want 0", stall); end
    tick();
    idle();
    #1;
    vecs++; if (busy[9] !== 1'b1 || rstall !== 2'b01) begin errs++; $display("FAIL busy_r9: got %b/%b want 1/01", busy[9], rstall); end
    we = 1; wclr = 1; waddr = 9; wdata = 32'hBEEF;
    #1;
    vecs++; if (rdata[31:0] !== 32'hBEEF || stall !== 1'b0) begin errs++; $display("FAIL wthru_r9: got %h/%b want beef/0", rdata[31:0], stall); end
    tick();
    idle();
    #1;
    vecs++; if (busy[9] !== 1'b0 || rdata[31:0] !== 32'hBEEF || stall !== 1'b0) begin errs++; $display("FAIL cleared_r9: got %b/%h/%b want 0/beef/0", busy[9], rdata[31:0], stall); end
  endtask

  task automatic test_collision();
    idle();
    busy_set = 1; busy_addr = 4;
    tick();
    busy_set = 1; busy_addr = 4;
    we = 1; wclr = 1; waddr = 4; wdata = 32'h10;
    tick();
    idle();
    raddr = {5'd0, 5'd4};
    #1;
    vecs++; if (busy[4] !== 1'b1) begin errs++; $display("FAIL collide_busy4: got %b want 1", busy[4]); end
    vecs++; if (rstall !== 2'b01 || rdata[31:0] !== 32'h10) begin errs++; $display("FAIL collide_read: got %b/%h want 01/10", rstall, rdata[31:0]); end
    busy_set = 1; busy_addr = 6;
    we = 1; wclr = 1; waddr = 4; wdata = 32'h20;
    tick();
    idle();
    #1;
    vecs++; if (busy[6] !== 1'b1 || busy[4] !== 1'b0) begin errs++; $display("FAIL split_set_clr: got %b%b want 10", busy[6], busy[4]); end
    raddr = {5'd0, 5'd6};
    we = 1; wclr = 0; waddr = 6; wdata = 32'h77;
    #1;
    vecs++; if (rdata[31:0] !== 32'h77 || rstall !== 2'b00) begin errs++; $display("FAIL wthru_busy: got %h/%b want 77/00", rdata[31:0], rstall); end
    tick();
    idle();
    #1;
    vecs++; if (busy[6] !== 1'b1 || rstall !== 2'b01 || rdata[31:0] !== 32'h77) begin errs++; $display("FAIL noclr_busy6: got %b/%b/%h want 1/01/77", busy[6], rstall, rdata[31:0]); end
  endtask

  task automatic test_zero();
    idle();
    raddr = {5'd0, 5'd0};
    we = 1; waddr = 0; wdata = 32'hFFFF;
    busy_set = 1; busy_addr = 0;
    fwd_bus[0*FW +: FW] = fe(1, 1, 0, 32'h9);
    #1;
    vecs++; if (rdata !== '0 || stall !== 1'b0) begin errs++; $display("FAIL r0_same: got %h/%b want 0/0", rdata, stall); end
    tick();
    idle();
    #1;
    vecs++; if (busy[0] !== 1'b0 || rdata[31:0] !== 32'h0 || stall !== 1'b0) begin errs++; $display("FAIL r0_after: got %b/%h/%b want 0/0/0", busy[0], rdata[31:0], stall); end
  endtask

  initial begin
    rst = 1; raddr = '0;
    idle();
    tick();
    tick();
    rst = 0;
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_scoreboard();
    test_collision();
    test_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
